des_key_schedule: RTL
=====================

# des_key_schedule

Generates the sixteen 48-bit DES round subkeys from a 64-bit key and holds them in an internal register file for the DES round datapath, which sits directly downstream. Applies PC-1 once, then one rotate-and-PC-2 step per clock, so the full schedule takes 16 round cycles. Uses the same enable/done/ack handshake as the cipher core. The core reads subkeys by round index: ascending order for encrypt, descending for decrypt.

## Interface
- No parameters. Constants (PC-1, PC-2, shift schedule) are fixed by FIPS 46-3.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  start request; sampled only in IDLE.
- DESkey  in  [7:0][7:0]  64-bit key; DESkey[7] is key byte 1; bit 63 is DES bit 1. Parity bits are ignored.
- ack  in  1  consumer acknowledge; sampled only in DONE.
- rd_idx  in  4  subkey read index, 0 = K1 … 15 = K16.
- rd_key  out  48  subkey at rd_idx (combinational read); bit 47 is PC-2 output bit 1.
- sk_valid  out  1  high for one cycle each time a subkey is written.
- sk_round  out  4  index written when sk_valid is high.
- sk_out  out  48  subkey written when sk_valid is high.
- busy  out  1  high in ROUND.
- done  out  1  high in DONE; means all 16 subkeys are valid.

## Operation
- FSM states: IDLE, ROUND, DONE (one-hot).
- IDLE, enable=1:
  - C ← PC-1 left half of DESkey (28 b); D ← PC-1 right half.
  - round ← 0; go to ROUND.
  - enable=0: stay in IDLE.
- ROUND, each cycle:
  - s = SHIFT[round], where SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C' = C rotated left by s; D' = D rotated left by s (28-bit rotate; bits wrap from MSB to LSB).
  - C ← C', D ← D'.
  - rf[round] ← PC-2({C',D'}); sk_valid=1, sk_round=round, sk_out=rf value.
  - If round==15: go to DONE. Otherwise round ← round+1.
  - round is a 4-bit counter that never wraps past 15.
- DONE: done=1 and rf holds K1..K16.
  - ack=1: go to IDLE. rf is retained, so subkeys stay readable after ack.
  - ack=0: stay in DONE.
- enable in ROUND or DONE is ignored. No restart mid-schedule.
- DESkey is sampled only on the start edge; later changes have no effect until the next start.
- enable and ack high together in DONE: ack wins, go to IDLE. enable is seen only on a later IDLE cycle.
- rd_key is valid for any index whose rf entry has been written. Reading an index being written this cycle returns the old value.
- Total rotation after 16 rounds is 28, so C and D equal their post-PC-1 values. This is a self-check invariant.

## Timing
- Reset (reset=0 at a clock edge):
  - State → IDLE; round, C, D → 0; all rf entries → 0.
  - sk_valid=0, sk_round=0, sk_out=0, busy=0, done=0.
  - rd_key=0 for every index.
- Reset asserted during ROUND or DONE aborts the schedule and clears rf on that edge.
- Latency:
  - Start edge E0 (IDLE with enable=1).
  - K(n) is written at edge E0+n, and sk_valid is high in the cycle before that edge.
  - done rises after edge E0+16; done is high from cycle 17 on.
- Handshake:
  - done stays high until an edge where ack=1; done=0 the cycle after.
  - Back-to-back: a new start is accepted at the earliest one cycle after ack.
- Outputs are registered, except rd_key (rf plus mux) and the sk_* outputs, which come from the ROUND datapath.

## Structure
- Package des_pkg:
  - PC1 and PC2 index tables, as localparam int arrays, 1-based DES numbering.
  - SHIFT schedule array.
  - key_state_t enum.
  - Typedefs half_t (28 b) and subkey_t (48 b).
  - Functions pc1(), pc2(), rotl28().
- Shared with the round datapath: subkey_t, and later IP/E/P/S-box tables.
- One sub-module: des_subkey_rf, a 16×48 register file with one write port, one combinational read port, and synchronous clear.

## Test plan
- Key 0x133457799BBCDFF1, enable pulse:
  - C0=0xF0CCAAF, D0=0x556678F after the start edge.
  - rd_key[0]=0x1B02EFFC7072 (K1); rd_key[15]=0xCB3D8B0E17F5 (K16).
  - done high exactly 16 cycles after start.
- Same key, observe stream: 16 sk_valid pulses on consecutive cycles, sk_round 0..15 in order, each sk_out equal to the rd_key readback.
- Hold ack=0 for 10 cycles in DONE: done stays 1, enable pulses are ignored, and rf is unchanged. Then ack=1 → IDLE, done=0 next cycle, rf retained.
- Assert reset=0 at round 7: state IDLE, all rd_key=0, done=0. Restart with key 0x0000000000000000: all 16 subkeys = 0.
- Key 0xFEFEFEFEFEFEFEFE (weak key, parity bits ignored): all 16 subkeys are identical, and C=D=0xFFFFFFF at the end.
- Change DESkey mid-schedule and toggle enable during ROUND: subkeys match the key sampled at the start, with no restart.

Source files
------------

// File: rtl/des_pkg.sv
// DES key-schedule constants, types and permutation helpers (FIPS 46-3).
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUNDS   = 16;
  localparam int unsigned ROUND_W  = 4;

  typedef logic [HALF_W-1:0]   half_t;
  typedef logic [SUBKEY_W-1:0] subkey_t;

  // One-hot schedule state.
  typedef enum logic [2:0] {
    KS_IDLE  = 3'b001,
    KS_ROUND = 3'b010,
    KS_DONE  = 3'b100
  } key_state_t;

  // Permuted choice 1: 64-bit key -> 56-bit C||D, 1-based DES bit numbers.
  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: 56-bit C||D -> 48-bit subkey, 1-based DES bit numbers.
  localparam int unsigned PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied before each round's PC-2.
  localparam int unsigned SHIFT [ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // DES bit 1 is the MSB; parity bits simply never get selected.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      r[6'(int'(CD_W) - 1 - i)] = 1'(key >> (KEY_W - PC1[i]));
    end
    return r;
  endfunction

  function automatic subkey_t pc2(input logic [CD_W-1:0] cd);
    subkey_t r;
    r = '0;
    for (int i = 0; i < int'(SUBKEY_W); i++) begin
      r[6'(int'(SUBKEY_W) - 1 - i)] = 1'(cd >> (CD_W - PC2[i]));
    end
    return r;
  endfunction

  // 28-bit rotate left: bits leaving the MSB re-enter at the LSB.
  function automatic half_t rotl28(input half_t h, input int unsigned s);
    logic [2*HALF_W-1:0] t;
    t = {h, h} << s;
    return t[2*HALF_W-1 -: HALF_W];
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Start/done/ack handshake, subkey read port and subkey write stream.
interface des_key_schedule_if;
  import des_pkg::*;

  logic            enable;
  logic [7:0][7:0] DESkey;
  logic            ack;
  logic [3:0]      rd_idx;
  subkey_t         rd_key;
  logic            sk_valid;
  logic [3:0]      sk_round;
  subkey_t         sk_out;
  logic            busy;
  logic            done;

  // Controller / consumer side.
  modport master (
    output enable, DESkey, ack, rd_idx,
    input  rd_key, sk_valid, sk_round, sk_out, busy, done
  );

  // Key schedule side.
  modport slave (
    input  enable, DESkey, ack, rd_idx,
    output rd_key, sk_valid, sk_round, sk_out, busy, done
  );
endinterface

// File: rtl/des_subkey_rf.sv
// 16 x 48 subkey register file: one write port, one combinational read port.
module des_subkey_rf
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [ROUND_W-1:0] waddr_i,
  input  subkey_t            wdata_i,
  input  logic [ROUND_W-1:0] raddr_i,
  output subkey_t            rdata_o
);

  subkey_t mem_q [ROUNDS];

  // Synchronous clear has priority over the write.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < int'(ROUNDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read returns pre-write contents when addressing the entry being written.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on start, then one rotate + PC-2 subkey per cycle.
module des_key_schedule
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  des_key_schedule_if.slave  bus
);

  key_state_t         state_q;
  logic [ROUND_W-1:0] round_q;
  half_t              c_q;
  half_t              d_q;
  logic               busy_q;
  logic               done_q;

  half_t              c_d;
  half_t              d_d;
  subkey_t            sk_key;
  logic               sk_we;

  // Round datapath: rotate both halves and form this round's subkey.
  always_comb begin
    c_d    = rotl28(c_q, SHIFT[round_q]);
    d_d    = rotl28(d_q, SHIFT[round_q]);
    sk_key = pc2({c_d, d_d});
    sk_we  = (state_q == KS_ROUND);
  end

  // Schedule FSM with C/D registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= KS_IDLE;
      round_q <= '0;
      c_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        KS_IDLE: begin
          if (bus.enable) begin
            {c_q, d_q} <= pc1(KEY_W'(bus.DESkey));
            round_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= KS_ROUND;
          end
        end
        KS_ROUND: begin
          c_q <= c_d;
          d_q <= d_d;
          if (round_q == ROUND_W'(ROUNDS - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= KS_DONE;
          end else begin
            round_q <= round_q + ROUND_W'(1);
          end
        end
        KS_DONE: begin
          if (bus.ack) begin
            done_q  <= 1'b0;
            state_q <= KS_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= KS_IDLE;
        end
      endcase
    end
  end

  des_subkey_rf u_rf (
    .clk     (clk),
    .clr_i   (!reset),
    .we_i    (sk_we),
    .waddr_i (round_q),
    .wdata_i (sk_key),
    .raddr_i (bus.rd_idx),
    .rdata_o (bus.rd_key)
  );

  // Write stream is zero outside ROUND so it only carries live subkeys.
  assign bus.sk_valid = sk_we;
  assign bus.sk_round = sk_we ? round_q : ROUND_W'(0);
  assign bus.sk_out   = sk_we ? sk_key : '0;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
